// File: rtl/decode_pkg.sv
// Shared decode-stage definitions: immediate formats, bubble value, register indices.
package decode_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_U = 3'b011,
    IMM_J = 3'b100
  } imm_src_e;

  localparam int unsigned ZERO = 0;
  localparam int unsigned A0   = 10;

  // Every ID/EX field takes this value (truncated to its width) when a bubble is loaded.
  localparam logic [63:0] BUBBLE = 64'd0;

  // 32-bit immediate for the selected format; reserved codes give zero.
  function automatic logic [31:0] imm_gen(input logic [31:0] instr, input logic [2:0] src);
    logic [31:0] imm;
    case (imm_src_e'(src))
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'd0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/regfile_bp.sv
// Register file: async reads, x0 hardwired to zero, optional write-through
// bypass enabled by DECODE_WB_BYPASS_EN.
module regfile_bp
  import decode_pkg::*;
#(
  parameter int unsigned D_WIDTH = 32,
  parameter int unsigned A_WIDTH = 5
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [A_WIDTH-1:0] wa_i,
  input  logic [D_WIDTH-1:0] wd_i,
  input  logic [A_WIDTH-1:0] ra1_i,
  input  logic [A_WIDTH-1:0] ra2_i,
  output logic [D_WIDTH-1:0] rd1_o,
  output logic [D_WIDTH-1:0] rd2_o,
  output logic [D_WIDTH-1:0] a0_o
);

  localparam int unsigned N_REGS = 2 ** A_WIDTH;

  logic [D_WIDTH-1:0] mem_q [N_REGS];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_i && (wa_i != A_WIDTH'(ZERO))) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  function automatic logic [D_WIDTH-1:0] rd_port(input logic [A_WIDTH-1:0] ra);
    logic [D_WIDTH-1:0] val;
    if (ra == A_WIDTH'(ZERO)) begin
      val = '0;
`ifdef DECODE_WB_BYPASS_EN
    end else if (we_i && (ra == wa_i)) begin
      val = wd_i;
`endif
    end else begin
      val = mem_q[ra];
    end
    return val;
  endfunction

  assign rd1_o = rd_port(ra1_i);
  assign rd2_o = rd_port(ra2_i);
  assign a0_o  = rd_port(A_WIDTH'(A0));

endmodule

// File: rtl/decode_stage_hz.sv
// Decode stage with load-use hazard detection and ID/EX pipeline register.
// Optional writeback bypass in the register file: DECODE_WB_BYPASS_EN.
module decode_stage_hz
  import decode_pkg::*;
#(
  parameter int unsigned D_WIDTH = 32,
  parameter int unsigned A_WIDTH = 5,
  parameter int unsigned CTRL_W  = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_d,
  input  logic [D_WIDTH-1:0] instr_d,
  input  logic [D_WIDTH-1:0] pc_d,
  input  logic [D_WIDTH-1:0] pc_plus4_d,
  input  logic [CTRL_W-1:0]  ctrl_d,
  input  logic               mem_read_d,
  input  logic [2:0]         imm_src_d,
  input  logic               we3,
  input  logic [A_WIDTH-1:0] a3,
  input  logic [D_WIDTH-1:0] wd3,
  input  logic               flush_e,
  output logic               stall_d,
  output logic               valid_e,
  output logic [CTRL_W-1:0]  ctrl_e,
  output logic               mem_read_e,
  output logic [D_WIDTH-1:0] rd1_e,
  output logic [D_WIDTH-1:0] rd2_e,
  output logic [D_WIDTH-1:0] imm_ext_e,
  output logic [D_WIDTH-1:0] pc_e,
  output logic [D_WIDTH-1:0] pc_plus4_e,
  output logic [A_WIDTH-1:0] rs1_e,
  output logic [A_WIDTH-1:0] rs2_e,
  output logic [A_WIDTH-1:0] rd_e,
  output logic [D_WIDTH-1:0] a0
);

  logic [A_WIDTH-1:0] rs1_c, rs2_c, rd_c;
  logic [D_WIDTH-1:0] rd1_c, rd2_c, imm_ext_c;
  logic [31:0]        imm32_c;
  logic               stall_c, bubble_c;

  logic               valid_q, mem_read_q;
  logic [CTRL_W-1:0]  ctrl_q;
  logic [D_WIDTH-1:0] rd1_q, rd2_q, imm_q, pc_q, pc4_q;
  logic [A_WIDTH-1:0] rs1_q, rs2_q, rd_q;

  assign rs1_c = A_WIDTH'(instr_d[19:15]);
  assign rs2_c = A_WIDTH'(instr_d[24:20]);
  assign rd_c  = A_WIDTH'(instr_d[11:7]);

  assign imm32_c   = imm_gen(instr_d[31:0], imm_src_d);
  assign imm_ext_c = D_WIDTH'($signed(imm32_c));

  regfile_bp #(
    .D_WIDTH (D_WIDTH),
    .A_WIDTH (A_WIDTH)
  ) u_rf (
    .clk   (clk),
    .we_i  (we3),
    .wa_i  (a3),
    .wd_i  (wd3),
    .ra1_i (rs1_c),
    .ra2_i (rs2_c),
    .rd1_o (rd1_c),
    .rd2_o (rd2_c),
    .a0_o  (a0)
  );

  // Load in execute whose destination feeds this instruction: hold decode one cycle.
  assign stall_c  = valid_d & valid_q & mem_read_q & (rd_q != A_WIDTH'(ZERO)) &
                    ((rd_q == rs1_c) | (rd_q == rs2_c));
  assign bubble_c = flush_e | stall_c | ~valid_d;
  assign stall_d  = stall_c;

  always_ff @(posedge clk) begin
    if (rst || bubble_c) begin
      valid_q    <= BUBBLE[0];
      ctrl_q     <= CTRL_W'(BUBBLE);
      mem_read_q <= BUBBLE[0];
      rd1_q      <= D_WIDTH'(BUBBLE);
      rd2_q      <= D_WIDTH'(BUBBLE);
      imm_q      <= D_WIDTH'(BUBBLE);
      pc_q       <= D_WIDTH'(BUBBLE);
      pc4_q      <= D_WIDTH'(BUBBLE);
      rs1_q      <= A_WIDTH'(BUBBLE);
      rs2_q      <= A_WIDTH'(BUBBLE);
      rd_q       <= A_WIDTH'(BUBBLE);
    end else begin
      valid_q    <= 1'b1;
      ctrl_q     <= ctrl_d;
      mem_read_q <= mem_read_d;
      rd1_q      <= rd1_c;
      rd2_q      <= rd2_c;
      imm_q      <= imm_ext_c;
      pc_q       <= pc_d;
      pc4_q      <= pc_plus4_d;
      rs1_q      <= rs1_c;
      rs2_q      <= rs2_c;
      rd_q       <= rd_c;
    end
  end

  assign valid_e    = valid_q;
  assign ctrl_e     = ctrl_q;
  assign mem_read_e = mem_read_q;
  assign rd1_e      = rd1_q;
  assign rd2_e      = rd2_q;
  assign imm_ext_e  = imm_q;
  assign pc_e       = pc_q;
  assign pc_plus4_e = pc4_q;
  assign rs1_e      = rs1_q;
  assign rs2_e      = rs2_q;
  assign rd_e       = rd_q;

endmodule

// File: tb/tb_decode_stage_hz.sv
// Scoreboard bench for decode_stage_hz; expectations follow DECODE_WB_BYPASS_EN.
module tb_decode_stage_hz;

  typedef struct packed {
    logic        valid;
    logic [11:0] ctrl;
    logic        mr;
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  rs1, rs2, rd;
  } idex_t;

  localparam logic [31:0] ADDI_X6_X5_1 = 32'h00128313;
  localparam logic [31:0] LW_X7        = 32'h00012383;
  localparam logic [31:0] ADD_X8_X7_X1 = 32'h00138433;
  localparam logic [31:0] LW_X0        = 32'h00012003;
  localparam logic [31:0] ADD_X8_X0_X1 = 32'h00100433;
  localparam logic [31:0] ADDI_X9_X3_0 = 32'h00018493;
  localparam logic [31:0] ADDI_X9_X0_0 = 32'h00000493;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, valid_d, mem_read_d, we3, flush_e;
  logic [31:0] instr_d, pc_d, pc_plus4_d, wd3;
  logic [11:0] ctrl_d;
  logic [2:0]  imm_src_d;
  logic [4:0]  a3;
  logic        stall_d, valid_e, mem_read_e;
  logic [11:0] ctrl_e;
  logic [31:0] rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e, a0;
  logic [4:0]  rs1_e, rs2_e, rd_e;

  decode_stage_hz #(.D_WIDTH(32), .A_WIDTH(5), .CTRL_W(12)) dut (
    .clk(clk), .rst(rst), .valid_d(valid_d), .instr_d(instr_d), .pc_d(pc_d),
    .pc_plus4_d(pc_plus4_d), .ctrl_d(ctrl_d), .mem_read_d(mem_read_d),
    .imm_src_d(imm_src_d), .we3(we3), .a3(a3), .wd3(wd3), .flush_e(flush_e),
    .stall_d(stall_d), .valid_e(valid_e), .ctrl_e(ctrl_e), .mem_read_e(mem_read_e),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_ext_e(imm_ext_e), .pc_e(pc_e),
    .pc_plus4_e(pc_plus4_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .a0(a0)
  );

  idex_t act;
  assign act = {valid_e, ctrl_e, mem_read_e, rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e,
                rs1_e, rs2_e, rd_e};

  logic [31:0] mdl_rf [32];
  logic        m_valid_e, m_mr_e;
  logic [4:0]  m_rd_e;
  idex_t       sb[$];
  int          n_vec, n_err;
  logic        stall_seen, exp_stall;
  logic [31:0] a0_seen, exp_a0, pc_cnt;

  function automatic logic [31:0] m_imm(input logic [31:0] i, input logic [2:0] s);
    logic [31:0] t;
    case (s)
      3'd0: m_imm = 32'($signed(i) >>> 20);
      3'd1: begin t = {i[31:25], i[11:7], 20'd0}; m_imm = 32'($signed(t) >>> 20); end
      3'd2: begin t = {i[31], i[7], i[30:25], i[11:8], 1'b0, 19'd0}; m_imm = 32'($signed(t) >>> 19); end
      3'd3: m_imm = {i[31:12], 12'd0};
      3'd4: begin t = {i[31], i[19:12], i[20], i[30:21], 1'b0, 11'd0}; m_imm = 32'($signed(t) >>> 11); end
      default: m_imm = 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
`ifdef DECODE_WB_BYPASS_EN
    if (we3 && (a3 == a)) return wd3;
`endif
    return mdl_rf[a];
  endfunction

  // Drive one decode cycle, push the expected ID/EX contents, clock it in.
  task automatic apply(input logic rst_v, input logic valid_v, input logic [31:0] instr_v,
                       input logic [11:0] ctrl_v, input logic mr_v, input logic [2:0] isrc_v,
                       input logic we_v, input logic [4:0] a3_v, input logic [31:0] wd_v,
                       input logic flush_v);
    idex_t e;
    logic [4:0] r1, r2;
    rst = rst_v; valid_d = valid_v; instr_d = instr_v; ctrl_d = ctrl_v; mem_read_d = mr_v;
    imm_src_d = isrc_v; we3 = we_v; a3 = a3_v; wd3 = wd_v; flush_e = flush_v;
    pc_d = pc_cnt; pc_plus4_d = pc_cnt + 32'd4;
    r1 = instr_v[19:15]; r2 = instr_v[24:20];
    exp_stall = valid_v & m_valid_e & m_mr_e & (m_rd_e != 5'd0) & ((m_rd_e == r1) | (m_rd_e == r2));
    exp_a0 = m_read(5'd10);
    if (rst_v || flush_v || exp_stall || !valid_v) e = '0;
    else e = '{valid: 1'b1, ctrl: ctrl_v, mr: mr_v, rd1: m_read(r1), rd2: m_read(r2),
               imm: m_imm(instr_v, isrc_v), pc: pc_cnt, pc4: pc_cnt + 32'd4,
               rs1: r1, rs2: r2, rd: instr_v[11:7]};
    sb.push_back(e);
    pc_cnt = pc_cnt + 32'd4;
    #1;
    stall_seen = stall_d; a0_seen = a0;
    @(posedge clk);
    if (we_v && a3_v != 5'd0) mdl_rf[a3_v] = wd_v;
    m_valid_e = e.valid; m_mr_e = e.mr; m_rd_e = e.rd;
    #1;
  endtask

  task automatic test_reset();
    idex_t e;
    for (int i = 1; i < 32; i++) begin
      apply(1'b1, 1'b1, $urandom, 12'hFFF, 1'b1, 3'd0, 1'b1, 5'(i), 32'hA000_0000 + 32'(i) * 32'h111, 1'b0);
      e = sb.pop_front(); n_vec++;
      if (act !== e || act !== '0) begin n_err++; $display("FAIL reset_zero: got %h want %h", act, e); end
    end
    apply(1'b0, 1'b0, 32'd0, 12'd0, 1'b0, 3'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    e = sb.pop_front(); n_vec++;
    if (act !== e) begin n_err++; $display("FAIL idle: got %h want %h", act, e); end
    n_vec++;
    if (a0_seen !== exp_a0 || a0_seen !== 32'hA000_0AAA) begin
      n_err++; $display("FAIL a0_out: got %h want %h", a0_seen, exp_a0);
    end
  endtask

  task automatic test_addi();
    idex_t e;
    apply(1'b0, 1'b0, 32'd0, 12'd0, 1'b0, 3'd0, 1'b1, 5'd5, 32'h1234, 1'b0);
    e = sb.pop_front(); n_vec++;
    if (act !== e) begin n_err++; $display("FAIL wb_x5: got %h want %h", act, e); end
    apply(1'b0, 1'b1, ADDI_X6_X5_1, 12'h0A5, 1'b0, 3'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    e = sb.pop_front(); n_vec++;
    if (act !== e) begin n_err++; $display("FAIL addi: got %h want %h", act, e); end
    n_vec++;
    if (rd1_e !== 32'h1234 || imm_ext_e !== 32'd1 || rd_e !== 5'd6 || valid_e !== 1'b1) begin
      n_err++; $display("FAIL addi_fields: got rd1=%h imm=%h rd=%0d v=%b want 1234/1/6/1", rd1_e, imm_ext_e, rd_e, valid_e);
    end
  endtask

  task automatic test_load_use();
    idex_t e;
    apply(1'b0, 1'b1, LW_X7, 12'h011, 1'b1, 3'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    e = sb.pop_front(); n_vec++;
    if (act !== e) begin n_err++; $display("FAIL lw_x7: got %h want %h", act, e); end
    apply(1'b0, 1'b1, ADD_X8_X7_X1, 12'h022, 1'b0, 3'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    e = sb.pop_front(); n_vec++;
    if (act !== e || stall_seen !== 1'b1 || valid_e !== 1'b0 || ctrl_e !== 12'd0) begin
      n_err++; $display("FAIL lu_stall: got stall=%b %h want stall=1 %h", stall_seen, act, e);
    end
    apply(1'b0, 1'b1, ADD_X8_X7_X1, 12'h022, 1'b0, 3'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    e = sb.pop_front(); n_vec++;
    if (act !== e || stall_seen !== 1'b0 || rs1_e !== 5'd7 || valid_e !== 1'b1) begin
      n_err++; $display("FAIL lu_release: got stall=%b %h want stall=0 %h", stall_seen, act, e);
    end
  endtask

  task automatic test_rd0();
    idex_t e;
    apply(1'b0, 1'b1, LW_X0, 12'h033, 1'b1, 3'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    e = sb.pop_front(); n_vec++;
    if (act !== e) begin n_err++; $display("FAIL lw_x0: got %h want %h", act, e); end
    apply(1'b0, 1'b1, ADD_X8_X0_X1, 12'h044, 1'b0, 3'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    e = sb.pop_front(); n_vec++;
    if (act !== e || stall_seen !== 1'b0 || valid_e !== 1'b1) begin
      n_err++; $display("FAIL rd0_nostall: got stall=%b %h want stall=0 %h", stall_seen, act, e);
    end
  endtask

  task automatic test_flush();
    idex_t e;
    apply(1'b0, 1'b1, ADDI_X6_X5_1, 12'h055, 1'b1, 3'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    e = sb.pop_front(); n_vec++;
    if (act !== e || act !== '0) begin n_err++; $display("FAIL flush: got %h want %h", act, e); end
    apply(1'b0, 1'b1, LW_X7, 12'h066, 1'b1, 3'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    e = sb.pop_front(); n_vec++;
    if (act !== e) begin n_err++; $display("FAIL flush_lw: got %h want %h", act, e); end
    apply(1'b0, 1'b1, ADD_X8_X7_X1, 12'h077, 1'b0, 3'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    e = sb.pop_front(); n_vec++;
    if (act !== e || stall_seen !== 1'b1 || act !== '0) begin
      n_err++; $display("FAIL flush_stall: got stall=%b %h want stall=1 %h", stall_seen, act, e);
    end
    apply(1'b0, 1'b1, ADD_X8_X7_X1, 12'h077, 1'b0, 3'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    e = sb.pop_front(); n_vec++;
    if (act !== e || stall_seen !== 1'b0 || valid_e !== 1'b1) begin
      n_err++; $display("FAIL one_bubble: got stall=%b %h want stall=0 %h", stall_seen, act, e);
    end
  endtask

  task automatic test_bypass();
    idex_t e;
    logic [31:0] want;
`ifdef DECODE_WB_BYPASS_EN
    want = 32'hDEAD_BEEF;
`else
    want = 32'hA000_0333;
`endif
    apply(1'b0, 1'b1, ADDI_X9_X3_0, 12'h088, 1'b0, 3'd0, 1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0);
    e = sb.pop_front(); n_vec++;
    if (act !== e || rd1_e !== want) begin n_err++; $display("FAIL bypass_x3: got %h want %h", rd1_e, want); end
    apply(1'b0, 1'b1, ADDI_X9_X3_0, 12'h088, 1'b0, 3'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    e = sb.pop_front(); n_vec++;
    if (act !== e || rd1_e !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL x3_stored: got %h want deadbeef", rd1_e); end
    apply(1'b0, 1'b1, ADDI_X9_X0_0, 12'h099, 1'b0, 3'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0);
    e = sb.pop_front(); n_vec++;
    if (act !== e || rd1_e !== 32'd0) begin n_err++; $display("FAIL x0_wr_same: got %h want 0", rd1_e); end
    apply(1'b0, 1'b1, ADDI_X9_X0_0, 12'h099, 1'b0, 3'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    e = sb.pop_front(); n_vec++;
    if (act !== e || rd1_e !== 32'd0) begin n_err++; $display("FAIL x0_wr_next: got %h want 0", rd1_e); end
  endtask

  task automatic test_reset_mid();
    idex_t e;
    apply(1'b0, 1'b1, LW_X7, 12'h0AA, 1'b1, 3'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    e = sb.pop_front(); n_vec++;
    if (act !== e) begin n_err++; $display("FAIL rm_lw: got %h want %h", act, e); end
    apply(1'b1, 1'b1, ADD_X8_X7_X1, 12'h0BB, 1'b0, 3'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    e = sb.pop_front(); n_vec++;
    if (act !== e || act !== '0) begin n_err++; $display("FAIL rm_reset: got %h want %h", act, e); end
    apply(1'b0, 1'b1, ADD_X8_X7_X1, 12'h0BB, 1'b0, 3'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    e = sb.pop_front(); n_vec++;
    if (act !== e || stall_seen !== 1'b0) begin
      n_err++; $display("FAIL rm_nostall: got stall=%b %h want stall=0 %h", stall_seen, act, e);
    end
    apply(1'b0, 1'b1, ADDI_X6_X5_1, 12'h0CC, 1'b0, 3'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    e = sb.pop_front(); n_vec++;
    if (act !== e || rd1_e !== 32'h1234) begin n_err++; $display("FAIL rm_x5_kept: got %h want 1234", rd1_e); end
  endtask

  task automatic test_back_to_back();
    idex_t e;
    for (int k = 0; k < 80; k++) begin
      apply(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), $urandom, 12'($urandom),
            1'($urandom), 3'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 31)),
            $urandom, ($urandom_range(0, 7) == 0));
      e = sb.pop_front(); n_vec++;
      if (act !== e || stall_seen !== exp_stall) begin
        n_err++; $display("FAIL stream[%0d]: got stall=%b %h want stall=%b %h", k, stall_seen, act, exp_stall, e);
      end
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0; pc_cnt = 32'h0000_1000;
    m_valid_e = 1'b0; m_mr_e = 1'b0; m_rd_e = 5'd0;
    for (int i = 0; i < 32; i++) mdl_rf[i] = 32'd0;
    rst = 1'b1; valid_d = 1'b0; instr_d = '0; pc_d = '0; pc_plus4_d = '0; ctrl_d = '0;
    mem_read_d = 1'b0; imm_src_d = '0; we3 = 1'b0; a3 = '0; wd3 = '0; flush_e = 1'b0;
    test_reset();
    test_addi();
    test_load_use();
    test_rd0();
    test_flush();
    test_bypass();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/decode_stage_hz.md
DECODE_STAGE_HZ -- requirements
Module: decode_stage_hz

Interface
REQ-001 Parameters SHALL be:
- D_WIDTH, 32, datapath width
- A_WIDTH, 5, register address width; register count is 2**A_WIDTH
- CTRL_W, 12, width of the packed control bundle from the control unit
REQ-002 Ports SHALL be:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- valid_d  in  1  decode slot holds a real instruction
- instr_d  in  D_WIDTH  instruction word
- pc_d  in  D_WIDTH  instruction PC
- pc_plus4_d  in  D_WIDTH  PC+4
- ctrl_d  in  CTRL_W  control bundle
- mem_read_d  in  1  instruction is a load
- imm_src_d  in  3  immediate format select
- we3  in  1  writeback enable
- a3  in  A_WIDTH  writeback address
- wd3  in  D_WIDTH  writeback data
- flush_e  in  1  squash the instruction entering execute
- stall_d  out  1  load-use hazard; fetch/decode must hold
- valid_e, ctrl_e, mem_read_e  out  1/CTRL_W/1  registered execute-stage copies
- rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e  out  D_WIDTH  registered operands
- rs1_e, rs2_e, rd_e  out  A_WIDTH  registered register indices
- a0  out  D_WIDTH  combinational contents of register 10
REQ-003 The block SHALL use one clock, clk; reset rst SHALL be synchronous and active-high.

Function
REQ-004 rs1 = instr_d[19:15], rs2 = instr_d[24:20], rd = instr_d[11:7].
REQ-005 The register file SHALL read asynchronously, write on the clk rising edge when we3=1 and a3!=0, and always read register 0 as zero.
REQ-006 Immediate extension SHALL be sign-extended to D_WIDTH: imm_src 000=I, 001=S, 010=B, 011=U (instr[31:12]<<12), 100=J; codes 101-111 SHALL yield zero.
REQ-007 stall_d SHALL be combinational and equal valid_d & valid_e & mem_read_e & (rd_e!=0) & (rd_e==rs1 | rd_e==rs2).
REQ-008 Each rising edge SHALL load the ID/EX register using this priority: rst, then flush_e, then stall_d, then normal load.
REQ-009 On rst, flush_e or stall_d, the register SHALL load a bubble: valid_e=0, ctrl_e=0, mem_read_e=0, rd_e=0; the other outputs are don't-care but SHALL be zero.
REQ-010 On a normal load, every *_e output SHALL capture its decode-side value with 1-cycle latency; pc_e SHALL capture pc_d (not pc_plus4_d).
REQ-011 If valid_d=0 on a normal load, the register SHALL load a bubble.
REQ-012 Register-file writes SHALL proceed regardless of stall_d, flush_e or valid_d.
REQ-013 flush_e asserted together with stall_d SHALL produce one bubble; stall_d SHALL still follow REQ-007.

Reset
REQ-014 rst SHALL clear every ID/EX output to zero on the next rising edge.
REQ-015 rst SHALL NOT clear register-file contents.
REQ-016 While rst=1, register-file writes SHALL proceed.
REQ-017 A reset asserted during a stall SHALL leave stall_d=0 on the following cycle.

Configuration
REQ-018 Macro DECODE_WB_BYPASS_EN: when defined, a read whose address equals a3 with we3=1 and a3!=0 SHALL return wd3 in the same cycle (write-through).
REQ-019 When DECODE_WB_BYPASS_EN is undefined, reads SHALL return the stored value, and the caller SHALL separate writeback from the dependent read by at least one cycle.

Structure
REQ-020 Package decode_pkg SHALL hold the imm_src encodings as an enum, the bubble constant, and the register index constants (ZERO=0, A0=10).
REQ-021 The register file SHALL be a separate sub-module, regfile_bp, parametrised by D_WIDTH and A_WIDTH, and it SHALL contain the bypass logic.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Write x5=0x1234 via we3, then decode addi x6,x5,1 (I, imm=1) -> next cycle rd1_e=0x1234, imm_ext_e=1, rd_e=6, valid_e=1.
- Load into x7 in execute (mem_read_e=1, rd_e=7), decode add x8,x7,x1 -> stall_d=1, following cycle valid_e=0 and ctrl_e=0, then after release the add enters with rs1_e=7.
- Same as above but rd_e=0 -> stall_d=0, no bubble.
- flush_e=1 with a valid instruction decoded -> valid_e=0, all *_e zero; flush_e+stall_d together -> exactly one bubble.
- With bypass enabled, we3=1, a3=3, wd3=0xDEADBEEF while decoding rs1=3 -> rd1_e=0xDEADBEEF; with bypass disabled -> the old x3 value. Write to x0 -> reads stay 0.
- Mid-stream rst for 1 cycle -> all *_e zero, stall_d=0, and x5 retains 0x1234.
